// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: datapath widths, default reset
// PC and the fetch control state encoding.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // FETCH issues requests; FLUSH waits for stale responses to drain.
    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used both for the in-flight request address
// queue and for the {instr, pc} buffer in front of decode. The caller never
// pushes when full (unless also popping) and never pops when empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// In-order instruction fetch stage. Holds the PC, issues word requests to
// instruction memory under a credit limit, buffers returned instructions with
// their PCs and hands them to decode. A redirect flushes the stream and the
// responses still in flight at that point are discarded as they return.
module instr_fetch #(
    parameter int              INSTR_WIDTH = riscv_pkg::INSTR_WIDTH,
    parameter int              XLEN        = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = riscv_pkg::RESET_PC,
    parameter int              FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [XLEN-1:0]        instr_pc,
    input  logic                   instr_ready
);

    import riscv_pkg::*;

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_t state, state_next;

    logic [XLEN-1:0]             pc;
    logic [XLEN-1:0]             redir_pc;
    logic [XLEN-1:0]             req_head;
    logic [CW-1:0]               outstanding;
    logic [CW-1:0]               drop_cnt;
    logic [CW-1:0]               drop_next;
    logic [CW-1:0]               ibuf_count;
    logic [CW-1:0]               req_count;
    logic [INSTR_WIDTH+XLEN-1:0] ibuf_head;
    logic                        ibuf_empty, ibuf_full, req_empty, req_full;
    logic                        req_fire, resp_fire, req_pop, enq, deq, credit_ok;
    logic                        unused;

    assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign req_fire  = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp_fire = imem_resp_valid & (outstanding != '0);
    assign req_pop   = resp_fire & (state == FETCH);
    assign enq       = req_pop & ~redirect_valid;
    assign deq       = instr_valid & instr_ready & ~redirect_valid;

    // Buffered plus in-flight instructions never exceed the buffer depth, so
    // every response in FETCH is guaranteed a free slot.
    assign credit_ok      = ({1'b0, ibuf_count} + {1'b0, outstanding}) < DEPTH_W;
    assign imem_req_valid = ~rst & (state == FETCH) & credit_ok & ~redirect_valid;
    assign imem_req_addr  = pc;

    assign instr_valid = ~ibuf_empty;
    assign instr       = instr_valid ? ibuf_head[INSTR_WIDTH+XLEN-1:XLEN] : '0;
    assign instr_pc    = instr_valid ? ibuf_head[XLEN-1:0] : '0;

    // Spare FIFO status and the ignored low redirect bits.
    assign unused = &{1'b0, req_count, req_full, req_empty, ibuf_full, redirect_pc[1:0]};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_req_pc (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (req_pop),
        .flush     (redirect_valid),
        .head      (req_head),
        .count     (req_count),
        .empty     (req_empty),
        .full      (req_full)
    );

    fetch_fifo #(.WIDTH(INSTR_WIDTH + XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .push_data ({imem_resp_data, req_head}),
        .pop       (deq),
        .flush     (redirect_valid),
        .head      (ibuf_head),
        .count     (ibuf_count),
        .empty     (ibuf_empty),
        .full      (ibuf_full)
    );

    // Next-state logic: enter FLUSH while stale responses remain to be dropped.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is itself dropped.
                    drop_next  = outstanding - CW'(resp_fire);
                    state_next = (drop_next == '0) ? FETCH : FLUSH;
                end
            end
            FLUSH: begin
                if (resp_fire) drop_next = drop_cnt - CW'(1);
                if (drop_next == '0) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // State register and stale-response counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    // PC advance/redirect and in-flight request count.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
        end else begin
            if (redirect_valid) pc <= redir_pc;
            else if (req_fire)  pc <= pc + XLEN'(4);
            case ({req_fire, resp_fire})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table for the corner
// cases, then randomized traffic against an in-bench memory and a stream
// model that tags each request with a redirect generation.
module tb_instr_fetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready  = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        redirect_valid  = 1'b0;
    logic [31:0] redirect_pc     = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready     = 1'b0;

    instr_fetch #(
        .INSTR_WIDTH (32),
        .XLEN        (32),
        .RESET_PC    (RST_PC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] addr;
        int          g;
    } pend_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    pend_t       pend_q[$];   // requests accepted by memory, in order
    ent_t        mq[$];       // instructions decode should see
    logic [31:0] m_pc;
    int          gen, cyc, last_due, lat;
    bit          cur_rdy, cur_mrdy, cur_redir, have_resp, exp_rv;
    logic [31:0] cur_rpc;

    task automatic model_reset(input int l);
        mq.delete();
        pend_q.delete();
        m_pc     = RST_PC;
        gen      = 0;
        cyc      = 0;
        last_due = -1;
        lat      = l;
    endtask

    // Drive one cycle's inputs (at the falling edge) and compare against the model.
    task automatic drive_cycle(input bit rdy, input bit mrdy, input bit spur,
                               input bit redir, input logic [31:0] rpc);
        int stale;
        cur_rdy  = rdy;
        cur_mrdy = mrdy;
        cur_redir = redir;
        cur_rpc  = rpc;
        instr_ready    = rdy;
        imem_req_ready = mrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        have_resp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        if (have_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_q[0].addr);
        end else if (spur && pend_q.size() == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        stale = 0;
        foreach (pend_q[i]) if (pend_q[i].g != gen) stale++;
        // Requests only when no stale response is pending, credit is
        // available and no redirect is being applied.
        exp_rv = (stale == 0) && (mq.size() + pend_q.size() < DEPTH) && !redir;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
        check("instr", instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
        check("instr_pc", instr_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    endtask

    // Advance the model across the rising edge that follows drive_cycle.
    task automatic commit_cycle();
        bit    deq;
        pend_t p;
        ent_t  e;
        int    d;
        deq = (mq.size() > 0) && cur_rdy && !cur_redir;
        if (cur_redir) mq.delete();
        else if (deq) e = mq.pop_front();
        if (have_resp) begin
            p = pend_q.pop_front();
            if (p.g == gen && !cur_redir) begin
                e.instr = mem_word(p.addr);
                e.pc    = p.addr;
                mq.push_back(e);
            end
        end
        if (exp_rv && cur_mrdy) begin
            d = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 5)));
            if (d <= last_due) d = last_due + 1;
            p.due  = d;
            p.addr = m_pc;
            p.g    = gen;
            pend_q.push_back(p);
            last_due = d;
            m_pc = m_pc + 32'd4;
        end
        if (cur_redir) begin
            m_pc = cur_rpc & 32'hFFFF_FFFC;
            gen++;
        end
        cyc++;
    endtask

    // Reset at the next falling edge (or a few ns into the current cycle for
    // a mid-operation reset), check outputs clear, release at a falling edge.
    task automatic apply_reset(input bit mid, input int l);
        if (mid) #2;
        else @(negedge clk);
        rst = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        instr_ready     = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(l);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rs;
        int          lat;
        bit          rdy, mrdy, spur, redir;
        logic [31:0] rpc;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];
    bit   nxt_rs  = 1'b0;
    int   nxt_lat = 1;

    task automatic tbl_reset(input int l);
        nxt_rs  = 1'b1;
        nxt_lat = l;
    endtask

    task automatic row(input bit rdy, input bit mrdy, input bit spur, input bit redir,
                       input logic [31:0] rpc, input bit erv, input logic [31:0] era,
                       input bit eiv, input logic [31:0] eipc);
        vec_t v;
        v.rs = nxt_rs; v.lat = nxt_lat;
        v.rdy = rdy; v.mrdy = mrdy; v.spur = spur; v.redir = redir; v.rpc = rpc;
        v.e_rv = erv; v.e_ra = era; v.e_iv = eiv; v.e_ipc = eipc;
        vecs.push_back(v);
        nxt_rs = 1'b0;
    endtask

    logic [31:0] r_rpc;

    initial begin
        // Streaming after reset, L=1, decode always ready.
        tbl_reset(1);
        row(1,1,0,0,0, 1,32'h00, 0,0);
        row(1,1,0,0,0, 1,32'h04, 0,0);
        row(1,1,0,0,0, 1,32'h08, 1,32'h00);
        row(1,1,0,0,0, 1,32'h0C, 1,32'h04);
        row(1,1,0,0,0, 1,32'h10, 1,32'h08);
        row(1,1,0,0,0, 1,32'h14, 1,32'h0C);
        // Decode stalled: four requests, then hold; release drains in order.
        tbl_reset(1);
        row(0,1,0,0,0, 1,32'h00, 0,0);
        row(0,1,0,0,0, 1,32'h04, 0,0);
        row(0,1,0,0,0, 1,32'h08, 1,32'h00);
        row(0,1,0,0,0, 1,32'h0C, 1,32'h00);
        row(0,1,0,0,0, 0,0,      1,32'h00);
        row(0,1,0,0,0, 0,0,      1,32'h00);
        row(0,1,0,0,0, 0,0,      1,32'h00);
        row(1,1,0,0,0, 0,0,      1,32'h00);
        row(1,1,0,0,0, 1,32'h10, 1,32'h04);
        row(1,1,0,0,0, 1,32'h14, 1,32'h08);
        row(1,1,0,0,0, 1,32'h18, 1,32'h0C);
        row(1,1,0,0,0, 1,32'h1C, 1,32'h10);
        // Redirect to 0x103 with three outstanding (L=4): drain, then 0x100.
        tbl_reset(4);
        row(1,1,0,0,0,         1,32'h000, 0,0);
        row(1,1,0,0,0,         1,32'h004, 0,0);
        row(1,1,0,0,0,         1,32'h008, 0,0);
        row(1,1,0,1,32'h103,   0,0,       0,0);
        row(1,1,0,0,0,         0,0,       0,0);
        row(1,1,0,0,0,         0,0,       0,0);
        row(1,1,0,0,0,         0,0,       0,0);
        row(1,1,0,0,0,         1,32'h100, 0,0);
        row(1,1,0,0,0,         1,32'h104, 0,0);
        row(1,1,0,0,0,         1,32'h108, 0,0);
        row(1,1,0,0,0,         1,32'h10C, 0,0);
        row(1,1,0,0,0,         0,0,       0,0);
        row(1,1,0,0,0,         0,0,       1,32'h100);
        row(1,1,0,0,0,         1,32'h110, 1,32'h104);
        // Redirect together with a response and a dequeue: no flush wait.
        tbl_reset(1);
        row(1,1,0,0,0,         1,32'h000, 0,0);
        row(1,1,0,0,0,         1,32'h004, 0,0);
        row(1,1,0,1,32'h200,   0,0,       1,32'h000);
        row(1,1,0,0,0,         1,32'h200, 0,0);
        row(1,1,0,0,0,         1,32'h204, 0,0);
        row(1,1,0,0,0,         1,32'h208, 1,32'h200);
        // PC wrap-around from the top of the address space.
        tbl_reset(1);
        row(1,1,0,1,32'hFFFF_FFFC, 0,0,            0,0);
        row(1,1,0,0,0,             1,32'hFFFF_FFFC, 0,0);
        row(1,1,0,0,0,             1,32'h0000_0000, 0,0);
        row(1,1,0,0,0,             1,32'h0000_0004, 1,32'hFFFF_FFFC);
        row(1,1,0,0,0,             1,32'h0000_0008, 1,32'h0000_0000);
        // Spurious responses with nothing outstanding are ignored.
        tbl_reset(1);
        row(1,0,1,0,0, 1,32'h00, 0,0);
        row(1,0,1,0,0, 1,32'h00, 0,0);
        row(1,1,0,0,0, 1,32'h00, 0,0);
        row(1,1,0,0,0, 1,32'h04, 0,0);
        row(1,1,0,0,0, 1,32'h08, 1,32'h00);

        model_reset(1);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rs) apply_reset(1'b0, vecs[i].lat);
            else @(negedge clk);
            drive_cycle(vecs[i].rdy, vecs[i].mrdy, vecs[i].spur, vecs[i].redir, vecs[i].rpc);
            check($sformatf("row%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                check($sformatf("row%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
            check($sformatf("row%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("row%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
                check($sformatf("row%0d_instr", i), instr, mem_word(vecs[i].e_ipc));
            end
            commit_cycle();
        end

        // Randomized traffic with random memory latency, back-pressure,
        // redirects (some near the top of the address space), spurious
        // responses and one mid-operation reset.
        apply_reset(1'b0, 0);
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) apply_reset(1'b1, 0);
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) r_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           r_rpc = $urandom & 32'h0000_FFFF;
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, r_rpc);
            commit_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
